// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the PC redirect controller: the PC-source select, FSM states
// and a helper that decodes an execute-stage control-flow request.
package pc_redirect_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_BR  = 2'd1,
        PC_JI  = 2'd2,
        PC_JR  = 2'd3
    } pcsel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } redir_state_t;

    localparam int unsigned FLUSH_CNT_W = 3;

    // PC_INC means the instruction does not redirect the PC.
    function automatic pcsel_t decode_redirect(logic jr, logic jump, logic branch, logic taken);
        if (jr) begin
            return PC_JR;
        end else if (jump) begin
            return PC_JI;
        end else if (branch && taken) begin
            return PC_BR;
        end
        return PC_INC;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bus between the execute-stage redirect controller (master) and the PC (slave).
interface pc_redirect_ctrl_if;
    import pc_redirect_ctrl_pkg::*;

    logic [25:0] jumpi_addr;
    logic [15:0] branch_addr;
    word_t       jr_addr;
    pcsel_t      pcsel;
    logic        redirect_valid;
    logic        halt;
    logic        pc_ready;

    modport master (
        output jumpi_addr,
        output branch_addr,
        output jr_addr,
        output pcsel,
        output redirect_valid,
        output halt,
        input  pc_ready
    );

    modport slave (
        input  jumpi_addr,
        input  branch_addr,
        input  jr_addr,
        input  pcsel,
        input  redirect_valid,
        input  halt,
        output pc_ready
    );

endinterface

// File: rtl/pc_redirect_ctrl_redirect_counter.sv
// Saturating event counter with enable and synchronous clear.
module redirect_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Registers execute-stage redirects toward the PC, holds them until accepted, then
// sequences the pipeline flush; HALT is latched until reset.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ex_valid,
    input  logic                 ex_halt,
    input  logic                 ex_jr,
    input  logic                 ex_jump,
    input  logic                 ex_branch,
    input  logic                 ex_br_taken,
    input  logic [25:0]          ex_imm26,
    input  logic [15:0]          ex_imm16,
    input  word_t                ex_jr_target,
    pc_redirect_ctrl_if.master   pc,
    output logic                 flush,
    output logic                 ex_stall,
    output logic [CNT_W-1:0]     redirect_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FlushInit = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    redir_state_t            state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    pcsel_t                  pcsel_q, pcsel_d;
    logic [25:0]             jumpi_q, jumpi_d;
    logic [15:0]             branch_q, branch_d;
    word_t                   jr_q, jr_d;
    logic                    valid_q, valid_d;
    logic                    halt_q, halt_d;
    logic                    flush_q, flush_d;
    logic                    stall_q, stall_d;

    pcsel_t req_sel;
    logic   accept;

    assign req_sel = decode_redirect(ex_jr, ex_jump, ex_branch, ex_br_taken);
    assign accept  = (state_q == HOLD) && valid_q && pc.pc_ready;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pcsel_d     = pcsel_q;
        jumpi_d     = jumpi_q;
        branch_d    = branch_q;
        jr_d        = jr_q;
        valid_d     = valid_q;
        halt_d      = halt_q;
        flush_d     = flush_q;
        stall_d     = stall_q;

        unique case (state_q)
            RUN: begin
                if (ex_valid) begin
                    if (ex_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                        stall_d = 1'b1;
                    end else if (req_sel != PC_INC) begin
                        state_d = HOLD;
                        pcsel_d = req_sel;
                        valid_d = 1'b1;
                        stall_d = 1'b1;
                        // Only the field the PC will consume is refreshed.
                        unique case (req_sel)
                            PC_JR:   jr_d     = ex_jr_target;
                            PC_JI:   jumpi_d  = ex_imm26;
                            PC_BR:   branch_d = ex_imm16;
                            default: ;
                        endcase
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d     = FLUSH;
                    valid_d     = 1'b0;
                    pcsel_d     = PC_INC;
                    flush_d     = 1'b1;
                    stall_d     = 1'b1;
                    flush_cnt_d = FlushInit;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                    flush_d = 1'b0;
                    stall_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            HALTED: begin
                halt_d  = 1'b1;
                valid_d = 1'b0;
                flush_d = 1'b0;
                stall_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            pcsel_q     <= PC_INC;
            jumpi_q     <= '0;
            branch_q    <= '0;
            jr_q        <= '0;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
            flush_q     <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pcsel_q     <= pcsel_d;
            jumpi_q     <= jumpi_d;
            branch_q    <= branch_d;
            jr_q        <= jr_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
            flush_q     <= flush_d;
            stall_q     <= stall_d;
        end
    end

    redirect_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_counter (
        .clk_i   (CLK),
        .clr_i   (RST),
        .en_i    (accept),
        .count_o (redirect_cnt)
    );

    assign pc.jumpi_addr     = jumpi_q;
    assign pc.branch_addr    = branch_q;
    assign pc.jr_addr        = jr_q;
    assign pc.pcsel          = pcsel_q;
    assign pc.redirect_valid = valid_q;
    assign pc.halt           = halt_q;
    assign flush             = flush_q;
    assign ex_stall          = stall_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized and directed bench for pc_redirect_ctrl, checked every cycle against a
// transaction-level model; a second instance with a 4-bit counter checks saturation.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    localparam int unsigned FlushCycles = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid, ex_halt, ex_jr, ex_jump, ex_branch, ex_br_taken;
    logic [25:0] ex_imm26;
    logic [15:0] ex_imm16;
    logic [31:0] ex_jr_target;
    logic        pc_ready;
    logic        flush, ex_stall, flush4, ex_stall4;
    logic [15:0] redirect_cnt;
    logic [3:0]  redirect_cnt4;

    pc_redirect_ctrl_if pc_if ();
    pc_redirect_ctrl_if pc4_if ();

    assign pc_if.pc_ready  = pc_ready;
    assign pc4_if.pc_ready = pc_ready;

    pc_redirect_ctrl #(.FLUSH_CYCLES(FlushCycles), .CNT_W(16)) u_dut (
        .CLK (CLK), .RST (RST), .ex_valid (ex_valid), .ex_halt (ex_halt), .ex_jr (ex_jr),
        .ex_jump (ex_jump), .ex_branch (ex_branch), .ex_br_taken (ex_br_taken),
        .ex_imm26 (ex_imm26), .ex_imm16 (ex_imm16), .ex_jr_target (ex_jr_target),
        .pc (pc_if), .flush (flush), .ex_stall (ex_stall), .redirect_cnt (redirect_cnt)
    );

    pc_redirect_ctrl #(.FLUSH_CYCLES(FlushCycles), .CNT_W(4)) u_dut4 (
        .CLK (CLK), .RST (RST), .ex_valid (ex_valid), .ex_halt (ex_halt), .ex_jr (ex_jr),
        .ex_jump (ex_jump), .ex_branch (ex_branch), .ex_br_taken (ex_br_taken),
        .ex_imm26 (ex_imm26), .ex_imm16 (ex_imm16), .ex_jr_target (ex_jr_target),
        .pc (pc4_if), .flush (flush4), .ex_stall (ex_stall4), .redirect_cnt (redirect_cnt4)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: a pending redirect, remaining flush cycles, a halted flag, accept count.
    bit          m_pending, m_halted;
    int unsigned m_flush_left, m_accepts;
    logic [1:0]  m_sel;
    logic [25:0] m_jumpi;
    logic [15:0] m_branch;
    logic [31:0] m_jr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_pending = 0; m_halted = 0; m_flush_left = 0; m_accepts = 0;
            m_sel = 2'd0; m_jumpi = '0; m_branch = '0; m_jr = '0;
        end else if (m_halted) begin
            // stays halted
        end else if (m_pending) begin
            if (pc_ready) begin
                m_pending    = 0;
                m_accepts++;
                m_flush_left = FlushCycles;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (ex_valid) begin
            if (ex_halt) begin
                m_halted = 1;
            end else if (ex_jr) begin
                m_pending = 1; m_sel = 2'd3; m_jr = ex_jr_target;
            end else if (ex_jump) begin
                m_pending = 1; m_sel = 2'd2; m_jumpi = ex_imm26;
            end else if (ex_branch && ex_br_taken) begin
                m_pending = 1; m_sel = 2'd1; m_branch = ex_imm16;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("redirect_valid", pc_if.redirect_valid, m_pending);
        check_eq("pcsel", pc_if.pcsel, m_pending ? m_sel : 2'd0);
        check_eq("halt", pc_if.halt, m_halted);
        check_eq("flush", flush, m_flush_left > 0);
        check_eq("ex_stall", ex_stall, m_pending || m_halted || (m_flush_left > 0));
        check_eq("jumpi_addr", pc_if.jumpi_addr, m_jumpi);
        check_eq("branch_addr", pc_if.branch_addr, m_branch);
        check_eq("jr_addr", pc_if.jr_addr, m_jr);
        check_eq("redirect_cnt", redirect_cnt, (m_accepts > 65535) ? 65535 : m_accepts);
        check_eq("redirect_cnt4", redirect_cnt4, (m_accepts > 15) ? 15 : m_accepts);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_halt = 0; ex_jr = 0; ex_jump = 0; ex_branch = 0; ex_br_taken = 0;
    endtask

    task automatic randomize_ex();
        ex_valid     = ($urandom_range(1) == 1);
        ex_halt      = ($urandom_range(149) == 0);
        ex_jr        = ($urandom_range(3) == 0);
        ex_jump      = ($urandom_range(3) == 0);
        ex_branch    = ($urandom_range(2) == 0);
        ex_br_taken  = ($urandom_range(1) == 1);
        ex_imm26     = 26'($urandom);
        ex_imm16     = 16'($urandom);
        ex_jr_target = $urandom;
        pc_ready     = ($urandom_range(1) == 1);
    endtask

    initial begin
        set_idle();
        ex_imm26 = '0; ex_imm16 = '0; ex_jr_target = '0; pc_ready = 0;

        // Reset
        RST = 1;
        cycle();
        cycle();
        RST = 0;
        check_eq("rst_pcsel", pc_if.pcsel, PC_INC);
        check_eq("rst_cnt", redirect_cnt, 16'd0);

        // Jump accepted immediately, then a two-cycle flush
        ex_valid = 1; ex_jump = 1; ex_imm26 = 26'h0000040; pc_ready = 1;
        cycle();
        set_idle();
        check_eq("j_addr", pc_if.jumpi_addr, 26'h40);
        check_eq("j_pcsel", pc_if.pcsel, PC_JI);
        check_eq("j_valid", pc_if.redirect_valid, 1'b1);
        cycle();
        check_eq("j_flush1", flush, 1'b1);
        check_eq("j_cnt", redirect_cnt, 16'd1);
        cycle();
        check_eq("j_flush2", flush, 1'b1);
        cycle();
        check_eq("j_flush_end", flush, 1'b0);
        check_eq("j_stall_end", ex_stall, 1'b0);

        // Taken branch held for four cycles under back-pressure
        ex_valid = 1; ex_branch = 1; ex_br_taken = 1; ex_imm16 = 16'hFFFC; pc_ready = 0;
        cycle();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            check_eq("br_hold_valid", pc_if.redirect_valid, 1'b1);
            check_eq("br_hold_addr", pc_if.branch_addr, 16'hFFFC);
            check_eq("br_hold_stall", ex_stall, 1'b1);
            pc_ready = (i == 3);
            cycle();
        end
        check_eq("br_flush", flush, 1'b1);
        check_eq("br_valid_drop", pc_if.redirect_valid, 1'b0);
        pc_ready = 0;
        cycle();
        cycle();

        // JR presented during flush is ignored
        ex_valid = 1; ex_jump = 1; ex_imm26 = 26'h3ABCDEF; pc_ready = 1;
        cycle();
        set_idle();
        cycle();
        ex_valid = 1; ex_jr = 1; ex_jr_target = 32'hDEAD_BEE0;
        cycle();
        cycle();
        set_idle();
        check_eq("flush_jr_ignored", pc_if.redirect_valid, 1'b0);
        check_eq("flush_jr_addr", pc_if.jr_addr, 32'h0);
        cycle();

        // Reset in the middle of HOLD
        ex_valid = 1; ex_branch = 1; ex_br_taken = 1; ex_imm16 = 16'h1234; pc_ready = 0;
        cycle();
        set_idle();
        RST = 1;
        cycle();
        RST = 0;
        check_eq("rst_hold_valid", pc_if.redirect_valid, 1'b0);
        check_eq("rst_hold_addr", pc_if.branch_addr, 16'h0);
        check_eq("rst_hold_stall", ex_stall, 1'b0);

        // Halt wins over JR and stays latched
        ex_valid = 1; ex_halt = 1; ex_jr = 1; ex_jr_target = 32'h0000_1000; pc_ready = 1;
        cycle();
        check_eq("halt_set", pc_if.halt, 1'b1);
        check_eq("halt_no_redirect", pc_if.redirect_valid, 1'b0);
        check_eq("halt_cnt", redirect_cnt, 16'd0);
        for (int i = 0; i < 10; i++) begin
            randomize_ex();
            cycle();
            check_eq("halt_sticky", pc_if.halt, 1'b1);
        end

        // Seventeen accepted redirects saturate the 4-bit counter
        RST = 1;
        set_idle();
        cycle();
        RST = 0;
        for (int i = 0; i < 17; i++) begin
            ex_valid = 1; ex_jr = 1; ex_jr_target = 32'h100 + i; pc_ready = 1;
            cycle();
            set_idle();
            for (int k = 0; k < 3; k++) cycle();
        end
        check_eq("sat_cnt4", redirect_cnt4, 4'hF);
        check_eq("sat_cnt16", redirect_cnt, 16'd17);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            randomize_ex();
            RST = ($urandom_range(199) == 0);
            cycle();
        end
        RST = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
